// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multicycle sequencer and its datapath/memory.
// Latency: none, wires only.
// Backpressure: memory stalls are signalled by holding mem_done low.
interface multicycle_sequencer_if;
    logic [5:0] opcode;
    logic       zFlag;
    logic       mem_done;
    logic       pc_ld;
    logic       ir_ld;
    logic       npc_ld;
    logic       mar_ld;
    logic       mdr_ld;
    logic       mar_sel;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       unSign;
    logic [1:0] alu_src;
    logic [2:0] alu_code;
    logic [1:0] pc_src;
    logic [3:0] state;
    logic       halted;
    logic       fault;

    // Sequencer side: consumes instruction/status, drives controls.
    modport master (
        input  opcode, zFlag, mem_done,
        output pc_ld, ir_ld, npc_ld, mar_ld, mdr_ld, mar_sel,
               mem_read, mem_write, reg_dst, reg_write, mem_to_reg, unSign,
               alu_src, alu_code, pc_src, state, halted, fault
    );

    // Datapath side: supplies instruction/status, consumes controls.
    modport slave (
        output opcode, zFlag, mem_done,
        input  pc_ld, ir_ld, npc_ld, mar_ld, mdr_ld, mar_sel,
               mem_read, mem_write, reg_dst, reg_write, mem_to_reg, unSign,
               alu_src, alu_code, pc_src, state, halted, fault
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control FSM: fetch, decode, execute, memory and write-back.
// Latency: 4 cycles branch/jump, 5 ALU/sw, 6 lw with single-cycle memory.
// Backpressure: waits in memory states until mem_done; faults after MEM_TIMEOUT stalls.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_sequencer_if.master        bus
);
    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        FETCH_ADDR = 4'd1,
        FETCH_WAIT = 4'd2,
        DECODE     = 4'd3,
        EXEC_R     = 4'd4,
        EXEC_I     = 4'd5,
        EXEC_ADDR  = 4'd6,
        MEM_RD     = 4'd7,
        MEM_WR     = 4'd8,
        WB_R       = 4'd9,
        WB_I       = 4'd10,
        WB_LD      = 4'd11,
        BRANCH     = 4'd12,
        JUMP       = 4'd13,
        HALT       = 4'd14,
        FAULT      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

    state_t     curState;
    state_t     nextState;
    logic [3:0] waitCnt;
    logic       waitState;
    logic       timedOut;

    logic       pcLd, irLd, npcLd, marLd, mdrLd, marSel;
    logic       memRead, memWrite, regDst, regWrite, memToReg, unSignOut;
    logic [1:0] aluSrc, pcSrc;
    logic [2:0] aluCode;

    assign waitState = (curState == FETCH_WAIT) || (curState == MEM_RD) || (curState == MEM_WR);
    // mem_done in the timeout cycle still completes the access normally.
    assign timedOut  = waitState && !bus.mem_done && (waitCnt == TIMEOUT_CNT);

    // State register; reset forces IDLE asynchronously, which zeroes every output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curState <= IDLE;
        end else begin
            curState <= nextState;
        end
    end

    // Wait counter: restarts on any state change (covers entry to each wait state),
    // counts stalled cycles while waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt <= 4'd0;
        end else if (nextState != curState) begin
            waitCnt <= 4'd0;
        end else if (waitState && !bus.mem_done) begin
            waitCnt <= waitCnt + 4'd1;
        end
    end

    // Next-state decode and Moore/Mealy control outputs.
    always_comb begin
        nextState = curState;
        pcLd      = 1'b0;
        irLd      = 1'b0;
        npcLd     = 1'b0;
        marLd     = 1'b0;
        mdrLd     = 1'b0;
        marSel    = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        regDst    = 1'b0;
        regWrite  = 1'b0;
        memToReg  = 1'b0;
        unSignOut = 1'b0;
        aluSrc    = 2'b00;
        aluCode   = 3'b000;
        pcSrc     = 2'b00;

        unique case (curState)
            IDLE: nextState = FETCH_ADDR;
            FETCH_ADDR: begin
                marLd     = 1'b1;
                nextState = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                memRead = 1'b1;
                irLd    = bus.mem_done;
                npcLd   = bus.mem_done;
                if (bus.mem_done) nextState = DECODE;
                else if (timedOut) nextState = FAULT;
            end
            DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                          nextState = EXEC_R;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: nextState = EXEC_I;
                    OP_LW, OP_SW:                      nextState = EXEC_ADDR;
                    OP_BEQ, OP_BNE:                    nextState = BRANCH;
                    OP_J:                              nextState = JUMP;
                    default:                           nextState = HALT;
                endcase
            end
            EXEC_R: nextState = WB_R;
            EXEC_I: begin
                aluSrc = 2'b01;
                case (bus.opcode)
                    OP_ADDI:  aluCode = 3'b001;
                    OP_ADDIU: begin aluCode = 3'b001; unSignOut = 1'b1; end
                    OP_ANDI:  begin aluCode = 3'b011; unSignOut = 1'b1; end
                    OP_ORI:   begin aluCode = 3'b100; unSignOut = 1'b1; end
                    default:  aluCode = 3'b000;
                endcase
                nextState = WB_I;
            end
            EXEC_ADDR: begin
                aluSrc  = 2'b01;
                aluCode = 3'b001;
                marLd   = 1'b1;
                marSel  = 1'b1;
                // Opcode changed under us since DECODE: stop rather than guess.
                if (bus.opcode == OP_LW)      nextState = MEM_RD;
                else if (bus.opcode == OP_SW) nextState = MEM_WR;
                else                          nextState = HALT;
            end
            MEM_RD: begin
                memRead = 1'b1;
                mdrLd   = bus.mem_done;
                if (bus.mem_done) nextState = WB_LD;
                else if (timedOut) nextState = FAULT;
            end
            MEM_WR: begin
                memWrite = 1'b1;
                pcLd     = bus.mem_done;
                if (bus.mem_done) nextState = FETCH_ADDR;
                else if (timedOut) nextState = FAULT;
            end
            WB_R: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                pcLd      = 1'b1;
                nextState = FETCH_ADDR;
            end
            WB_I: begin
                regWrite  = 1'b1;
                pcLd      = 1'b1;
                nextState = FETCH_ADDR;
            end
            WB_LD: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                pcLd      = 1'b1;
                nextState = FETCH_ADDR;
            end
            BRANCH: begin
                aluCode = 3'b010;
                pcLd    = 1'b1;
                if (((bus.opcode == OP_BEQ) && bus.zFlag) ||
                    ((bus.opcode == OP_BNE) && !bus.zFlag)) pcSrc = 2'b01;
                nextState = FETCH_ADDR;
            end
            JUMP: begin
                pcLd      = 1'b1;
                pcSrc     = 2'b10;
                nextState = FETCH_ADDR;
            end
            HALT:  nextState = HALT;
            FAULT: nextState = FAULT;
            default: nextState = IDLE;
        endcase
    end

    assign bus.pc_ld      = pcLd;
    assign bus.ir_ld      = irLd;
    assign bus.npc_ld     = npcLd;
    assign bus.mar_ld     = marLd;
    assign bus.mdr_ld     = mdrLd;
    assign bus.mar_sel    = marSel;
    assign bus.mem_read   = memRead;
    assign bus.mem_write  = memWrite;
    assign bus.reg_dst    = regDst;
    assign bus.reg_write  = regWrite;
    assign bus.mem_to_reg = memToReg;
    assign bus.unSign     = unSignOut;
    assign bus.alu_src    = aluSrc;
    assign bus.alu_code   = aluCode;
    assign bus.pc_src     = pcSrc;
    assign bus.state      = curState;
    assign bus.halted     = (curState == HALT);
    assign bus.fault      = (curState == FAULT);
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for the multicycle sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
// Every test starts from a fresh reset with its own opcode/flag setup.
module tb_multicycle_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    multicycle_sequencer_if busIf ();

    multicycle_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All control outputs except state/halted/fault, packed for a single compare.
    function automatic logic [18:0] ctrlVec();
        return {busIf.pc_ld, busIf.ir_ld, busIf.npc_ld, busIf.mar_ld, busIf.mdr_ld,
                busIf.mar_sel, busIf.mem_read, busIf.mem_write, busIf.reg_dst,
                busIf.reg_write, busIf.mem_to_reg, busIf.unSign, busIf.alu_src,
                busIf.alu_code, busIf.pc_src};
    endfunction

    // Stimulus only: set inputs, hold reset two cycles, release on a falling edge.
    task automatic pulseReset(input logic [5:0] op, input logic z, input logic md);
        @(negedge clk);
        reset = 1'b0;
        busIf.opcode = op;
        busIf.zFlag = z;
        busIf.mem_done = md;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        busIf.mem_done = 1'b1;
        #2;
        checks++;
        if (busIf.state !== 4'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", busIf.state); end
        checks++;
        if ({ctrlVec(), busIf.halted, busIf.fault} !== 21'd0) begin
            failures++; $display("FAIL reset_outputs: got %h want 0", {ctrlVec(), busIf.halted, busIf.fault});
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busIf.state !== 4'd1) begin failures++; $display("FAIL reset_release_fetch: got %0d want 1", busIf.state); end
    endtask

    task automatic test_itype();
        int seq[6] = '{1, 2, 3, 5, 10, 1};
        pulseReset(6'b001000, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (busIf.state !== 4'(seq[i])) begin
                failures++; $display("FAIL itype_seq[%0d]: got %0d want %0d", i, busIf.state, seq[i]);
            end
            if (i == 0) begin
                checks++;
                if ({busIf.mar_ld, busIf.mar_sel} !== 2'b10) begin
                    failures++; $display("FAIL itype_fetch_addr: got %b want 10", {busIf.mar_ld, busIf.mar_sel});
                end
            end
            if (i == 1) begin
                checks++;
                if ({busIf.mem_read, busIf.ir_ld, busIf.npc_ld} !== 3'b111) begin
                    failures++; $display("FAIL itype_fetch_wait: got %b want 111", {busIf.mem_read, busIf.ir_ld, busIf.npc_ld});
                end
            end
            if (i == 3) begin
                checks++;
                if ({busIf.alu_src, busIf.alu_code, busIf.unSign} !== 6'b01_001_0) begin
                    failures++; $display("FAIL itype_exec: got %b want 010010", {busIf.alu_src, busIf.alu_code, busIf.unSign});
                end
            end
            if (i == 4) begin
                checks++;
                if ({busIf.reg_write, busIf.pc_ld, busIf.reg_dst, busIf.pc_src} !== 5'b11000) begin
                    failures++; $display("FAIL itype_wb: got %b want 11000", {busIf.reg_write, busIf.pc_ld, busIf.reg_dst, busIf.pc_src});
                end
            end
        end
    endtask

    task automatic test_ori_unsigned();
        pulseReset(6'b001101, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({busIf.state, busIf.alu_src, busIf.alu_code, busIf.unSign} !== {4'd5, 2'b01, 3'b100, 1'b1}) begin
            failures++; $display("FAIL ori_exec: got %h want %h",
                {busIf.state, busIf.alu_src, busIf.alu_code, busIf.unSign}, {4'd5, 2'b01, 3'b100, 1'b1});
        end
    endtask

    task automatic test_rtype();
        pulseReset(6'b000000, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({busIf.state, ctrlVec()} !== {4'd4, 19'd0}) begin
            failures++; $display("FAIL rtype_exec: got %h want %h", {busIf.state, ctrlVec()}, {4'd4, 19'd0});
        end
        @(negedge clk);
        checks++;
        if ({busIf.state, busIf.reg_write, busIf.reg_dst, busIf.pc_ld} !== {4'd9, 3'b111}) begin
            failures++; $display("FAIL rtype_wb: got %h want %h", {busIf.state, busIf.reg_write, busIf.reg_dst, busIf.pc_ld}, {4'd9, 3'b111});
        end
        @(negedge clk);
        checks++;
        if (busIf.state !== 4'd1) begin failures++; $display("FAIL rtype_cycle: got %0d want 1", busIf.state); end
    endtask

    task automatic test_lw();
        pulseReset(6'b100011, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({busIf.state, busIf.mar_ld, busIf.mar_sel, busIf.alu_src, busIf.alu_code} !== {4'd6, 2'b11, 2'b01, 3'b001}) begin
            failures++; $display("FAIL lw_exec_addr: got %h want %h",
                {busIf.state, busIf.mar_ld, busIf.mar_sel, busIf.alu_src, busIf.alu_code}, {4'd6, 2'b11, 2'b01, 3'b001});
        end
        busIf.mem_done = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3) begin
                busIf.mem_done = 1'b1;
                #1;
            end
            checks++;
            if ({busIf.state, busIf.mem_read, busIf.mdr_ld} !== {4'd7, 1'b1, (c == 3)}) begin
                failures++; $display("FAIL lw_mem_rd[%0d]: got %h want %h", c,
                    {busIf.state, busIf.mem_read, busIf.mdr_ld}, {4'd7, 1'b1, (c == 3)});
            end
        end
        @(negedge clk);
        checks++;
        if ({busIf.state, busIf.mem_read, busIf.mem_to_reg, busIf.reg_write, busIf.reg_dst} !== {4'd11, 4'b0110}) begin
            failures++; $display("FAIL lw_wb: got %h want %h",
                {busIf.state, busIf.mem_read, busIf.mem_to_reg, busIf.reg_write, busIf.reg_dst}, {4'd11, 4'b0110});
        end
        @(negedge clk);
        checks++;
        if (busIf.state !== 4'd1) begin failures++; $display("FAIL lw_cycle: got %0d want 1", busIf.state); end
    endtask

    task automatic test_sw();
        pulseReset(6'b101011, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if ({busIf.state, busIf.mem_write, busIf.pc_ld, busIf.pc_src} !== {4'd8, 4'b1100}) begin
            failures++; $display("FAIL sw_mem_wr: got %h want %h", {busIf.state, busIf.mem_write, busIf.pc_ld, busIf.pc_src}, {4'd8, 4'b1100});
        end
        @(negedge clk);
        checks++;
        if ({busIf.state, busIf.mem_write} !== {4'd1, 1'b0}) begin
            failures++; $display("FAIL sw_cycle: got %h want 10", {busIf.state, busIf.mem_write});
        end
    endtask

    task automatic test_branch();
        pulseReset(6'b000100, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({busIf.state, busIf.pc_ld, busIf.pc_src, busIf.alu_code, busIf.alu_src} !== {4'd12, 1'b1, 2'b01, 3'b010, 2'b00}) begin
            failures++; $display("FAIL beq_taken: got %h want %h",
                {busIf.state, busIf.pc_ld, busIf.pc_src, busIf.alu_code, busIf.alu_src}, {4'd12, 1'b1, 2'b01, 3'b010, 2'b00});
        end
        busIf.opcode = 6'b000101;
        @(negedge clk);
        checks++;
        if (busIf.state !== 4'd1) begin failures++; $display("FAIL branch_cycle: got %0d want 1", busIf.state); end
        repeat (3) @(negedge clk);
        checks++;
        if ({busIf.state, busIf.pc_ld, busIf.pc_src} !== {4'd12, 1'b1, 2'b00}) begin
            failures++; $display("FAIL bne_not_taken: got %h want %h", {busIf.state, busIf.pc_ld, busIf.pc_src}, {4'd12, 1'b1, 2'b00});
        end
    endtask

    task automatic test_jump();
        pulseReset(6'b000010, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({busIf.state, busIf.pc_ld, busIf.pc_src} !== {4'd13, 1'b1, 2'b10}) begin
            failures++; $display("FAIL jump: got %h want %h", {busIf.state, busIf.pc_ld, busIf.pc_src}, {4'd13, 1'b1, 2'b10});
        end
        @(negedge clk);
        checks++;
        if (busIf.state !== 4'd1) begin failures++; $display("FAIL jump_cycle: got %0d want 1", busIf.state); end
    endtask

    task automatic test_halt();
        pulseReset(6'b111111, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if ({busIf.state, busIf.halted, busIf.fault} !== {4'd14, 2'b10}) begin
            failures++; $display("FAIL halt_enter: got %h want %h", {busIf.state, busIf.halted, busIf.fault}, {4'd14, 2'b10});
        end
        for (int i = 0; i < 20; i++) begin
            busIf.opcode   = 6'($urandom);
            busIf.zFlag    = 1'($urandom);
            busIf.mem_done = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({busIf.state, busIf.halted, ctrlVec()} !== {4'd14, 1'b1, 19'd0}) begin
                failures++; $display("FAIL halt_hold[%0d]: got %h want %h", i,
                    {busIf.state, busIf.halted, ctrlVec()}, {4'd14, 1'b1, 19'd0});
            end
        end
    endtask

    task automatic test_timeout();
        pulseReset(6'b001000, 1'b0, 1'b0);
        @(negedge clk);
        for (int w = 1; w <= 16; w++) begin
            @(negedge clk);
            checks++;
            if ({busIf.state, busIf.mem_read, busIf.fault} !== {4'd2, 2'b10}) begin
                failures++; $display("FAIL timeout_wait[%0d]: got %h want %h", w, {busIf.state, busIf.mem_read, busIf.fault}, {4'd2, 2'b10});
            end
        end
        @(negedge clk);
        checks++;
        if ({busIf.state, busIf.fault, busIf.halted, busIf.mem_read} !== {4'd15, 3'b100}) begin
            failures++; $display("FAIL timeout_fault: got %h want %h",
                {busIf.state, busIf.fault, busIf.halted, busIf.mem_read}, {4'd15, 3'b100});
        end
        busIf.mem_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busIf.state, busIf.fault} !== {4'd15, 1'b1}) begin
            failures++; $display("FAIL fault_hold: got %h want %h", {busIf.state, busIf.fault}, {4'd15, 1'b1});
        end
    endtask

    task automatic test_timeout_edge();
        pulseReset(6'b001000, 1'b0, 1'b0);
        @(negedge clk);
        repeat (15) @(negedge clk);
        @(negedge clk);
        busIf.mem_done = 1'b1;
        #1;
        checks++;
        if ({busIf.state, busIf.ir_ld} !== {4'd2, 1'b1}) begin
            failures++; $display("FAIL edge_wait16: got %h want %h", {busIf.state, busIf.ir_ld}, {4'd2, 1'b1});
        end
        @(negedge clk);
        checks++;
        if ({busIf.state, busIf.fault} !== {4'd3, 1'b0}) begin
            failures++; $display("FAIL edge_decode: got %h want %h", {busIf.state, busIf.fault}, {4'd3, 1'b0});
        end
    endtask

    task automatic test_reset_mid();
        pulseReset(6'b101011, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        busIf.mem_done = 1'b0;
        @(negedge clk);
        checks++;
        if ({busIf.state, busIf.mem_write} !== {4'd8, 1'b1}) begin
            failures++; $display("FAIL mid_mem_wr: got %h want %h", {busIf.state, busIf.mem_write}, {4'd8, 1'b1});
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({busIf.state, busIf.mem_write} !== {4'd0, 1'b0}) begin
            failures++; $display("FAIL mid_async_reset: got %h want 0", {busIf.state, busIf.mem_write});
        end
        @(negedge clk);
        reset = 1'b1;
        busIf.mem_done = 1'b1;
        #1;
        checks++;
        if (busIf.state !== 4'd0) begin failures++; $display("FAIL mid_release_idle: got %0d want 0", busIf.state); end
        @(negedge clk);
        checks++;
        if (busIf.state !== 4'd1) begin failures++; $display("FAIL mid_release_fetch: got %0d want 1", busIf.state); end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        busIf.opcode   = 6'd0;
        busIf.zFlag    = 1'b0;
        busIf.mem_done = 1'b0;
        test_reset();
        test_itype();
        test_ori_unsigned();
        test_rtype();
        test_lw();
        test_sw();
        test_branch();
        test_jump();
        test_halt();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
